fade_sequencer: RTL and testbench
=================================

FADE_SEQUENCER -- requirements
Module: fade_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, width of the palette address.
REQ-002 SHALL have parameter DWELL_W, default 28, width of the dwell counter; 50,000,000 cycles is 1 s at 50 MHz.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port enable  input  1  level; permits new transitions to start.
REQ-006 SHALL have port restart  input  1  single-cycle synchronous pulse; returns the sequence to its initial position.
REQ-007 SHALL have port mode  input  2  play mode: 00 loop, 01 ping-pong, 10 one-shot, 11 hold (paused).
REQ-008 SHALL have port last_index  input  ADDR_W  highest palette address in use.
REQ-009 SHALL have port dwell_cycles  input  DWELL_W  hold time after each completed fade.
REQ-010 SHALL have port fade_done  input  1  single-cycle pulse from the fading controller.
REQ-011 SHALL have port color_addr  output  ADDR_W  palette address driven to the color memory.
REQ-012 SHALL have port fade_start  output  1  single-cycle pulse requesting a fade to the color at color_addr.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port dir  output  1  sequence direction: 0 up, 1 down.
REQ-015 SHALL have port seq_done  output  1  sticky flag; one-shot sequence completed.

Function
REQ-016 SHALL implement a four-state FSM with states IDLE, START, FADING and DWELL; all outputs SHALL be registered or decoded from state.
REQ-017 In IDLE, SHALL move to START when enable=1, mode!=11 and seq_done=0; otherwise it SHALL remain in IDLE.
REQ-018 START SHALL last exactly one cycle:
- fade_start=1 only in START;
- next state is FADING.
REQ-019 In FADING, SHALL wait for fade_done=1, then move to DWELL and load the dwell counter with dwell_cycles.
- fade_done seen in any other state SHALL be ignored.
REQ-020 In DWELL, SHALL decrement the counter each cycle. When the counter is 0, it SHALL advance the address per REQ-022..025 and take the next state:
- START if enable=1 and mode!=11;
- IDLE otherwise.
REQ-021 dwell_cycles=0 SHALL give exactly one cycle in DWELL; dwell_cycles=N SHALL give N+1 cycles.
REQ-022 Loop mode: next address = 0 if color_addr>=last_index, else color_addr+1.
REQ-023 Ping-pong mode:
- dir=0 at last_index: set dir=1 and go to last_index-1;
- dir=1 at 0: set dir=0 and go to 1;
- last_index=0: address stays 0.
REQ-024 One-shot mode: at color_addr>=last_index, set seq_done=1, keep the address unchanged and go to IDLE; otherwise color_addr+1.
REQ-025 Hold mode: the address SHALL NOT change; the FSM SHALL go to IDLE at the end of DWELL.
REQ-026 If color_addr>last_index when an advance occurs (last_index lowered mid-run), the next address SHALL be 0 and dir SHALL be 0, in every mode.
REQ-027 color_addr SHALL change only at the DWELL exit edge or on restart; it SHALL be stable from START through the end of DWELL.
REQ-028 mode, last_index and enable SHALL be sampled only at decision points (IDLE, DWELL exit); changes during START or FADING SHALL NOT abort the fade in progress.
REQ-029 restart SHALL take priority over all FSM activity, including a simultaneous fade_done:
- sets color_addr=0, dir=0, seq_done=0;
- clears the dwell counter;
- sets state=IDLE;
- no fade_start is issued in that cycle.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_W. The dwell counter SHALL NOT underflow.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, color_addr=0, dir=0, fade_start=0, busy=0, seq_done=0, dwell counter=0.
REQ-032 Reset asserted mid-fade SHALL drop fade_start and busy immediately. After release, operation SHALL resume only through IDLE->START per REQ-017.

Verification
REQ-033 Loop: last_index=4, dwell_cycles=3, fade_done 10 cycles after each fade_start -> color_addr sequence 0,1,2,3,4,0,1; 4 cycles in DWELL each time.
REQ-034 Ping-pong: last_index=2 -> addresses 0,1,2,1,0,1; dir toggles to 1 after address 2 and back to 0 after address 0.
REQ-035 One-shot: last_index=2 -> addresses 0,1,2; then seq_done=1, busy=0, no further fade_start; a restart pulse -> seq_done=0, color_addr=0.
REQ-036 Hold: set mode=11 during FADING at address 1 -> fade completes; FSM goes to IDLE with color_addr=1; back to mode=00 -> fade_start issued with color_addr=1.
REQ-037 Edge cases, each checked separately:
- restart in the same cycle as fade_done -> IDLE, color_addr=0, no DWELL entered;
- lower last_index from 4 to 1 while color_addr=3 -> next address 0;
- dwell_cycles=0 -> one cycle in DWELL.
REQ-038 Reset pulse during FADING -> all outputs reach their reset values before the next clk edge; a fade_done arriving after release is ignored.

Source files
------------

// File: rtl/fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fade_sequencer
// Description : Walks a palette address through a color table, requesting a
//               fade to each entry and holding for a programmable dwell time.
//               Supports loop, ping-pong, one-shot and hold play modes.
// Revision    : 1.0 - initial release
// ============================================================================
module fade_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 28
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  last_index,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               fade_done,
    output logic [ADDR_W-1:0]  color_addr,
    output logic               fade_start,
    output logic               busy,
    output logic               dir,
    output logic               seq_done
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_start  = 2'd1;
    localparam logic [1:0] c_st_fading = 2'd2;
    localparam logic [1:0] c_st_dwell  = 2'd3;

    localparam logic [1:0] c_mode_loop = 2'b00;
    localparam logic [1:0] c_mode_ping = 2'b01;
    localparam logic [1:0] c_mode_one  = 2'b10;
    localparam logic [1:0] c_mode_hold = 2'b11;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_dir;
    logic               r_seq_done;
    logic [DWELL_W-1:0] r_cnt;

    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_dir_nxt;
    logic               w_done_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_run;

    // Next-state, address-advance and dwell-count decode
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_dir_nxt   = r_dir;
        w_done_nxt  = r_seq_done;
        w_cnt_nxt   = r_cnt;
        w_run       = enable && (mode != c_mode_hold);
        case (r_state)
            c_st_idle: begin
                if (w_run && !r_seq_done) begin
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                w_state_nxt = c_st_fading;
            end
            c_st_fading: begin
                if (fade_done) begin
                    w_cnt_nxt   = dwell_cycles;
                    w_state_nxt = c_st_dwell;
                end
            end
            default: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = w_run ? c_st_start : c_st_idle;
                    if (r_addr > last_index) begin
                        // Table shrank under us: restart from the bottom going up
                        w_addr_nxt = '0;
                        w_dir_nxt  = 1'b0;
                    end else begin
                        case (mode)
                            c_mode_loop: begin
                                w_addr_nxt = (r_addr >= last_index) ? '0 : r_addr + 1'b1;
                            end
                            c_mode_ping: begin
                                if (last_index == '0) begin
                                    w_addr_nxt = '0;
                                end else if (!r_dir) begin
                                    if (r_addr >= last_index) begin
                                        w_dir_nxt  = 1'b1;
                                        w_addr_nxt = last_index - 1'b1;
                                    end else begin
                                        w_addr_nxt = r_addr + 1'b1;
                                    end
                                end else begin
                                    if (r_addr == '0) begin
                                        w_dir_nxt  = 1'b0;
                                        w_addr_nxt = ADDR_W'(1);
                                    end else begin
                                        w_addr_nxt = r_addr - 1'b1;
                                    end
                                end
                            end
                            c_mode_one: begin
                                if (r_addr >= last_index) begin
                                    w_done_nxt  = 1'b1;
                                    w_state_nxt = c_st_idle;
                                end else begin
                                    w_addr_nxt = r_addr + 1'b1;
                                end
                            end
                            default: begin
                                w_state_nxt = c_st_idle;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // State and datapath registers; restart overrides everything but reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_dir      <= 1'b0;
            r_seq_done <= 1'b0;
            r_cnt      <= '0;
        end else if (restart) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_dir      <= 1'b0;
            r_seq_done <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_dir      <= w_dir_nxt;
            r_seq_done <= w_done_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign color_addr = r_addr;
    assign dir        = r_dir;
    assign seq_done   = r_seq_done;
    assign fade_start = (r_state == c_st_start);
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fade_sequencer
// Description : Scoreboard bench for fade_sequencer. Each expected fade
//               request is queued when stimulus is set up; a monitor pops and
//               compares on every fade_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fade_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  last_index = 3'd0;
    logic [27:0] dwell_cycles = 28'd0;
    logic        fade_done;
    logic [2:0]  color_addr;
    logic        fade_start;
    logic        busy;
    logic        dir;
    logic        seq_done;

    logic        fd_auto = 1'b0;
    logic        fd_man  = 1'b0;
    logic        auto_en = 1'b1;
    assign fade_done = fd_auto | fd_man;

    typedef struct {
        logic [2:0] addr;
        logic       dir;
        int         gap;   // cycles from fade_done to fade_start, -1 = unchecked
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_fd = 0;

    fade_sequencer #(.ADDR_W(3), .DWELL_W(28)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .restart      (restart),
        .mode         (mode),
        .last_index   (last_index),
        .dwell_cycles (dwell_cycles),
        .fade_done    (fade_done),
        .color_addr   (color_addr),
        .fade_start   (fade_start),
        .busy         (busy),
        .dir          (dir),
        .seq_done     (seq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fading controller model: answers each fade_start after about 10 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (fade_start) begin
                repeat (9) @(posedge clk);
                #1;
                if (auto_en) begin
                    fd_auto = 1'b1;
                    @(posedge clk);
                    #1 fd_auto = 1'b0;
                end
            end
        end
    end

    // Monitor: compare each fade request against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (fade_done) last_fd = cyc;
        if (fade_start) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_fade_start: addr=%0d dir=%0d, required none", color_addr, dir);
            end else begin
                e = sb.pop_front();
                if (color_addr !== e.addr || dir !== e.dir || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fade_req: addr=%0d dir=%0d busy=%0d, required addr=%0d dir=%0d busy=1",
                             color_addr, dir, busy, e.addr, e.dir);
                end
                if (e.gap >= 0) begin
                    n_tests++;
                    if (cyc - last_fd != e.gap) begin
                        n_fail++;
                        $display("FAIL dwell_gap: got %0d cycles, required %0d", cyc - last_fd, e.gap);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int a, input int d, input int g);
        exp_t e;
        e.addr = a[2:0];
        e.dir  = d[0];
        e.gap  = g;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d requests outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic pulse_restart();
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_addr", color_addr, 0);
        check("rst_dir", dir, 0);
        check("rst_fade_start", fade_start, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_done", seq_done, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Loop: 0,1,2,3,4,0,1 with 4 dwell cycles (gap = dwell + 2)
        mode = 2'b00; last_index = 3'd4; dwell_cycles = 28'd3;
        push(0, 0, -1);
        push(1, 0, 5); push(2, 0, 5); push(3, 0, 5);
        push(4, 0, 5); push(0, 0, 5); push(1, 0, 5);
        enable = 1'b1;
        wait_empty("loop");
        enable = 1'b0;
        wait_idle("loop");
        check("loop_end_addr", color_addr, 2);
        pulse_restart();
        check("restart_addr", color_addr, 0);

        // Ping-pong: 0,1,2,1,0,1 with direction turning at the ends
        mode = 2'b01; last_index = 3'd2; dwell_cycles = 28'd1;
        push(0, 0, -1); push(1, 0, 3); push(2, 0, 3);
        push(1, 1, 3); push(0, 1, 3); push(1, 0, 3);
        enable = 1'b1;
        wait_empty("ping");
        enable = 1'b0;
        wait_idle("ping");
        pulse_restart();

        // One-shot: 0,1,2 then sticky seq_done and no more requests
        mode = 2'b10; last_index = 3'd2; dwell_cycles = 28'd2;
        push(0, 0, -1); push(1, 0, 4); push(2, 0, 4);
        enable = 1'b1;
        wait_empty("oneshot");
        wait_idle("oneshot");
        check("oneshot_done", seq_done, 1);
        check("oneshot_addr", color_addr, 2);
        repeat (30) @(negedge clk);
        check("oneshot_stays_idle", busy, 0);
        enable = 1'b0;
        pulse_restart();
        check("oneshot_restart_done", seq_done, 0);
        check("oneshot_restart_addr", color_addr, 0);

        // Hold: pause during the fade at address 1, then resume at address 1
        mode = 2'b00; last_index = 3'd4; dwell_cycles = 28'd1;
        push(0, 0, -1); push(1, 0, 3);
        enable = 1'b1;
        wait_empty("hold");
        @(posedge clk);
        #1 mode = 2'b11;
        wait_idle("hold");
        check("hold_addr", color_addr, 1);
        push(1, 0, -1);
        mode = 2'b00;
        wait_empty("hold_resume");
        enable = 1'b0;
        wait_idle("hold_resume");
        pulse_restart();

        // dwell_cycles=0 gives a single DWELL cycle; then restart beats fade_done
        auto_en = 1'b0;
        dwell_cycles = 28'd0;
        push(0, 0, -1);
        enable = 1'b1;
        wait_empty("dwell0_a");
        push(1, 0, 2);
        @(posedge clk); #1 fd_man = 1'b1;
        @(posedge clk); #1 fd_man = 1'b0;
        wait_empty("dwell0_b");
        enable = 1'b0;
        @(posedge clk);
        #1 fd_man = 1'b1; restart = 1'b1;
        @(posedge clk);
        #1 fd_man = 1'b0; restart = 1'b0;
        check("rs_fd_busy", busy, 0);
        check("rs_fd_addr", color_addr, 0);
        check("rs_fd_dir", dir, 0);
        repeat (3) @(negedge clk);
        check("rs_fd_no_dwell", busy, 0);

        // Lowering last_index below the current address wraps to 0
        auto_en = 1'b1;
        dwell_cycles = 28'd1;
        push(0, 0, -1); push(1, 0, 3); push(2, 0, 3); push(3, 0, 3);
        enable = 1'b1;
        wait_empty("shrink_a");
        last_index = 3'd1;
        push(0, 0, 3);
        wait_empty("shrink_b");
        enable = 1'b0;
        wait_idle("shrink");
        pulse_restart();

        // Reset pulse mid-fade: outputs drop at once; later fade_done ignored
        last_index = 3'd4;
        push(0, 0, -1); push(1, 0, 3);
        enable = 1'b1;
        wait_empty("rstfade");
        auto_en = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check("rstfade_busy", busy, 0);
        check("rstfade_fade_start", fade_start, 0);
        check("rstfade_addr", color_addr, 0);
        check("rstfade_dir", dir, 0);
        check("rstfade_seq_done", seq_done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 fd_man = 1'b1;
        @(posedge clk);
        #1 fd_man = 1'b0;
        repeat (3) @(negedge clk);
        check("rstfade_fd_ignored", busy, 0);
        check("rstfade_fd_addr", color_addr, 0);
        push(0, 0, -1);
        auto_en = 1'b1;
        enable = 1'b1;
        wait_empty("rstfade_resume");
        enable = 1'b0;
        wait_idle("rstfade_resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
